// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the multi-channel tick generator.
//   CNT_W_DEFAULT   : default divisor/counter width (100 MHz down to 1 Hz fits in 27 bits)
//   DEF_DIV_DEFAULT : default reset divisor (1 kHz ticks from a 100 MHz clock)
//   ch_idx_t        : channel index carried on the write port
//   div_t           : divisor at the default width
package tick_gen_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 27;
  localparam int unsigned DEF_DIV_DEFAULT = 100000;
  localparam int unsigned MAX_CH          = 8;

  typedef logic [2:0]               ch_idx_t;
  typedef logic [CNT_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: free-running divider with a double-buffered divisor.
//   clk_i       : system clock
//   rst_ni      : synchronous active-low reset
//   en_i        : count enable; low freezes the counter and forces tick low
//   sync_clr_i  : zero the counter and apply any pending divisor
//   wr_i        : divisor write strobe already decoded for this channel
//   wr_div_i    : divisor value to write
//   tick_o      : registered one-cycle pulse on each wrap
//   pend_o      : a written divisor is waiting to become active
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;

  logic running;
  logic wrap;
  logic apply;

  always_comb begin
    running    = en_i && (act_div_q != '0);
    wrap       = running && (cnt_q == act_div_q - One);
    apply      = 1'b0;
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;

    if (sync_clr_i) begin
      cnt_d = '0;
      apply = 1'b1;
    end else if (running) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        apply  = 1'b1;
      end else begin
        cnt_d = cnt_q + One;
      end
    end else begin
      // Idle channel: a new divisor may land at any time. Restart the period
      // when it does so the counter can never sit above the new divisor.
      apply = 1'b1;
      if (pend_q || wr_i) begin
        cnt_d = '0;
      end
    end

    // When not pending, pend_div_q already equals act_div_q, so applying is harmless.
    if (apply) begin
      act_div_d  = wr_i ? wr_div_i : pend_div_q;
      pend_div_d = act_div_d;
      pend_d     = 1'b0;
    end else if (wr_i) begin
      pend_div_d = wr_div_i;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      act_div_q  <= DefDiv;
      pend_div_q <= DefDiv;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/multi_tick_generator.sv
// N_CH independent programmable tick channels sharing enable, clear and a write port.
//   clk      : system clock
//   rstn     : synchronous active-low reset
//   en       : global count enable
//   sync_clr : zero all counters together, applying pending divisors
//   wr_en    : divisor write strobe
//   wr_ch    : channel index for the write (indices >= N_CH are ignored)
//   wr_div   : new divisor
//   tick     : per-channel one-cycle enable pulse
//   pend     : per-channel "written divisor not yet active"
module multi_tick_generator
  import tick_gen_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [2:0]       wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pend
);

  ch_idx_t         wr_idx;
  logic [N_CH-1:0] wr_hit;

  assign wr_idx = wr_ch;

  // Only indices that exist get a strobe, so out-of-range writes fall through.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr_hit[i] = wr_en && (wr_idx == ch_idx_t'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    tick_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_i      (clk),
      .rst_ni     (rstn),
      .en_i       (en),
      .sync_clr_i (sync_clr),
      .wr_i       (wr_hit[g]),
      .wr_div_i   (wr_div),
      .tick_o     (tick[g]),
      .pend_o     (pend[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_generator.sv
module tb_multi_tick_generator;

  localparam int unsigned NCh    = 4;
  localparam int unsigned CntW   = 27;
  localparam int unsigned DefDiv = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            en;
  logic            sync_clr;
  logic            wr_en;
  logic [2:0]      wr_ch;
  logic [CntW-1:0] wr_div;
  logic [NCh-1:0]  tick;
  logic [NCh-1:0]  pend;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_tick_generator #(
    .N_CH    (NCh),
    .CNT_W   (CntW),
    .DEF_DIV (DefDiv)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .sync_clr (sync_clr),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .tick     (tick),
    .pend     (pend)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge, then sample away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_set(input logic [2:0] ch, input logic [CntW-1:0] div);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = div;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] exp_tick,
                          input logic [3:0] exp_pend);
    cyc();
    wr_en = 1'b0;
    check_eq({tag, "_tick"}, 32'(tick), 32'(exp_tick));
    check_eq({tag, "_pend"}, 32'(pend), 32'(exp_pend));
  endtask

  // Edges 13..28: ch1 div 3, ch2 switches to 5 at its wrap on edge 16.
  logic [3:0] exp_t3 [16] = '{4'b0000, 4'b0000, 4'b0010, 4'b1101,
                              4'b0000, 4'b0010, 4'b0000, 4'b1001,
                              4'b0110, 4'b0000, 4'b0000, 4'b1011,
                              4'b0000, 4'b0100, 4'b0010, 4'b1001};
  // After ch0 goes off: ch1 div3, ch2 div5, ch3 div4.
  logic [3:0] exp_t5 [6]  = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0100, 4'b0010};
  // After sync_clr with divs 3,4,5,7.
  logic [3:0] exp_t6 [7]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0010,
                              4'b0100, 4'b0001, 4'b1000};

  initial begin
    rstn = 1'b0; en = 1'b0; sync_clr = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    cyc();
    cyc();
    check_eq("rst_tick", 32'(tick), 32'h0);
    check_eq("rst_pend", 32'(pend), 32'h0);

    // 1: defaults, all channels aligned, tick on every 4th edge.
    rstn = 1'b1;
    en   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step_chk("t1", (k % 4 == 0) ? 4'hF : 4'h0, 4'h0);
    end

    // 2: write ch1=3 while its cnt is 1; period of 4 completes first.
    step_chk("t2_e9", 4'h0, 4'h0);
    wr_set(3'd1, 27'd3);
    step_chk("t2_wr", 4'h0, 4'b0010);
    step_chk("t2_e11", 4'h0, 4'b0010);
    step_chk("t2_wrap", 4'hF, 4'h0);

    // 3: write ch2=5 exactly in its wrap cycle (edge 16).
    for (int k = 0; k < 16; k++) begin
      if (k == 3) wr_set(3'd2, 27'd5);
      step_chk("t3", exp_t3[k], 4'h0);
    end

    // 4: freeze with ch0 at cnt 2, then resume.
    step_chk("t4_e29", 4'h0, 4'h0);
    step_chk("t4_e30", 4'b0010, 4'h0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step_chk("t4_frz", 4'h0, 4'h0);
    end
    en = 1'b1;
    step_chk("t4_a1", 4'b0100, 4'h0);
    step_chk("t4_a2", 4'b1001, 4'h0);
    step_chk("t4_a3", 4'b0010, 4'h0);

    // 5: ch0 off via div 0, then div 1 ticks every cycle.
    wr_set(3'd0, 27'd0);
    step_chk("t5_wr0", 4'h0, 4'b0001);
    step_chk("t5_a5", 4'h0, 4'b0001);
    step_chk("t5_a6", 4'hF, 4'h0);
    for (int k = 0; k < 6; k++) begin
      step_chk("t5_off", exp_t5[k], 4'h0);
    end
    wr_set(3'd0, 27'd1);
    step_chk("t5_wr1", 4'h0, 4'h0);
    step_chk("t5_a14", 4'b1001, 4'h0);
    step_chk("t5_a15", 4'b0011, 4'h0);
    step_chk("t5_a16", 4'b0101, 4'h0);

    // 6: drift with divs 3,4,5,7, then sync_clr re-aligns.
    wr_set(3'd0, 27'd3); cyc();
    wr_set(3'd1, 27'd4); cyc();
    wr_set(3'd2, 27'd5); cyc();
    wr_set(3'd3, 27'd7); cyc();
    wr_en = 1'b0;
    repeat (20) cyc();
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    check_eq("t6_clr_tick", 32'(tick), 32'h0);
    check_eq("t6_clr_pend", 32'(pend), 32'h0);
    for (int k = 0; k < 7; k++) begin
      step_chk("t6_drift", exp_t6[k], 4'h0);
    end

    // Equal divisors; last one written together with sync_clr.
    wr_set(3'd0, 27'd6); cyc();
    wr_set(3'd1, 27'd6); cyc();
    wr_set(3'd2, 27'd6); cyc();
    wr_set(3'd3, 27'd6);
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    wr_en    = 1'b0;
    check_eq("t6_clr2_tick", 32'(tick), 32'h0);
    check_eq("t6_clr2_pend", 32'(pend), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step_chk("t6_eq", (k == 6) ? 4'hF : 4'h0, 4'h0);
    end

    // Out-of-range channel write changes nothing.
    wr_set(3'd7, 27'd2);
    step_chk("t6_wr7", 4'h0, 4'h0);
    for (int k = 8; k <= 12; k++) begin
      step_chk("t6_wr7_run", (k == 12) ? 4'hF : 4'h0, 4'h0);
    end

    // Reset mid-count discards a pending write.
    wr_set(3'd1, 27'd2);
    step_chk("t6_pre", 4'h0, 4'b0010);
    step_chk("t6_hold", 4'h0, 4'b0010);
    rstn = 1'b0;
    cyc();
    check_eq("t6_rst_tick", 32'(tick), 32'h0);
    check_eq("t6_rst_pend", 32'(pend), 32'h0);
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step_chk("t6_post", (k == 4) ? 4'hF : 4'h0, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
